seq_divider: RTL and testbench

//   Multi-cycle integer divider for DIV/DIVU, complementing the single-cycle ALU in the execute stage.

---
 rtl/seq_divider_pkg.sv | 12 +
 rtl/seq_divider_div_step.sv | 23 ++
 rtl/seq_divider.sv | 114 +++++++++++
 tb/tb_seq_divider.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared types and defaults for the sequential integer divider.
package seq_divider_pkg;

  localparam int unsigned DataWidthDefault = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } div_state_e;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, subtract if it fits.
module seq_divider_div_step #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rem_in,
  input  logic [DATA_WIDTH-1:0] q_in,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] rem_out,
  output logic [DATA_WIDTH-1:0] q_out
);

  // Shifted partial remainder needs one extra bit before the compare.
  logic [DATA_WIDTH:0] shifted;
  logic                fits;

  always_comb begin
    shifted = {rem_in, q_in[DATA_WIDTH-1]};
    fits    = shifted >= {1'b0, divisor};
    rem_out = fits ? DATA_WIDTH'(shifted - {1'b0, divisor}) : shifted[DATA_WIDTH-1:0];
    q_out   = {q_in[DATA_WIDTH-2:0], fits};
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle DIV/DIVU unit: fixed DATA_WIDTH iterations, valid/ready on both sides.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DataWidthDefault
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  input  logic                  is_signed,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  div_by_zero
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(DATA_WIDTH - 1);

  div_state_e            state_q;
  logic [CntW-1:0]       count_q;
  logic [DATA_WIDTH-1:0] rem_q, q_q, b_mag_q, dividend_q;
  logic                  sa_q, sb_q, zero_q;
  logic [DATA_WIDTH-1:0] step_rem, step_q;
  logic [DATA_WIDTH-1:0] q_fix, r_fix;
  logic                  sa_in, sb_in;

  seq_divider_div_step #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_div_step (
    .rem_in (rem_q),
    .q_in   (q_q),
    .divisor(b_mag_q),
    .rem_out(step_rem),
    .q_out  (step_q)
  );

  assign in_ready = (state_q == StIdle);
  assign sa_in    = is_signed & dividend[DATA_WIDTH-1];
  assign sb_in    = is_signed & divisor[DATA_WIDTH-1];

  // Sign fix applied to the final iteration's result; zero divisor overrides it.
  always_comb begin
    q_fix = (sa_q ^ sb_q) ? -step_q : step_q;
    r_fix = sa_q ? -step_rem : step_rem;
    if (zero_q) begin
      q_fix = '1;
      r_fix = dividend_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      count_q     <= '0;
      rem_q       <= '0;
      q_q         <= '0;
      b_mag_q     <= '0;
      dividend_q  <= '0;
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
      zero_q      <= 1'b0;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (flush) begin
      state_q   <= StIdle;
      count_q   <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            state_q    <= StBusy;
            count_q    <= '0;
            rem_q      <= '0;
            q_q        <= sa_in ? -dividend : dividend;
            b_mag_q    <= sb_in ? -divisor : divisor;
            dividend_q <= dividend;
            sa_q       <= sa_in;
            sb_q       <= sb_in;
            zero_q     <= (divisor == '0);
          end
        end
        StBusy: begin
          rem_q   <= step_rem;
          q_q     <= step_q;
          count_q <= count_q + 1'b1;
          if (count_q == LastCnt) begin
            state_q     <= StDone;
            out_valid   <= 1'b1;
            quotient    <= q_fix;
            remainder   <= r_fix;
            div_by_zero <= zero_q;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q   <= StIdle;
            out_valid <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: latency, signed/unsigned results, backpressure, abort.
module tb_seq_divider;

  localparam int unsigned W = 32;
  localparam int unsigned Latency = W + 1;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } exp_t;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         is_signed = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb_q[$];

  seq_divider #(
    .DATA_WIDTH(W)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .is_signed  (is_signed),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t e;
    int   sa, sbv;
    e.dz = 1'b0;
    if (b == '0) begin
      e.q  = '1;
      e.r  = a;
      e.dz = 1'b1;
    end else if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        e.q = 32'h8000_0000;
        e.r = '0;
      end else begin
        sa  = a;
        sbv = b;
        e.q = sa / sbv;
        e.r = sa % sbv;
      end
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  // Present one request and let it be accepted on the next edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input bit push);
    @(negedge clk);
    check("accept_ready", 32'(in_ready), 32'd1);
    dividend  = a;
    divisor   = b;
    is_signed = s;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (push) sb_q.push_back(model(a, b, s));
  endtask

  // Wait for out_valid (bounded), then check latency, in_ready and the scoreboard head.
  task automatic wait_result(input string tag);
    int   lat;
    bit   rdy_seen;
    exp_t e;
    lat      = 1;
    rdy_seen = 1'b0;
    while (!out_valid && lat < 200) begin
      if (in_ready) rdy_seen = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(Latency));
    check({tag, "_busy_ready"}, 32'(rdy_seen), 32'd0);
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_q"}, quotient, e.q);
      check({tag, "_r"}, remainder, e.r);
      check({tag, "_dz"}, 32'(div_by_zero), 32'(e.dz));
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("drain_out_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s);
    start_op(a, b, s, 1'b1);
    wait_result(tag);
    drain();
  endtask

  initial begin
    logic [W-1:0] hold_q, hold_r;
    bit           seen;

    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_quotient", quotient, 32'd0);
    check("rst_remainder", remainder, 32'd0);
    check("rst_dz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    run_op("divu_100_7", 32'd100, 32'd7, 1'b0);
    run_op("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1);
    run_op("div_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1);
    run_op("div_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run_op("divu_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("div_by0_s", 32'h1234_5678, 32'd0, 1'b1);
    run_op("divu_by0", 32'h1234_5678, 32'd0, 1'b0);
    run_op("div_by0_neg", 32'h8765_4321, 32'd0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      run_op($sformatf("rand%0d", i), $urandom, $urandom >> (i * 4), i[0]);
    end

    // Backpressure with a competing request held high in DONE.
    start_op(32'd1000, 32'd33, 1'b0, 1'b1);
    wait_result("bp");
    hold_q    = quotient;
    hold_r    = remainder;
    dividend  = 32'd5;
    divisor   = 32'd1;
    in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_q_stable", quotient, hold_q);
      check("bp_r_stable", remainder, hold_r);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("bp_release_out_valid", 32'(out_valid), 32'd0);
    check("bp_release_idle", 32'(in_ready), 32'd1);

    // Flush on the 10th BUSY cycle.
    start_op(32'd999, 32'd3, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_idle", 32'(in_ready), 32'd1);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check("flush_no_result", 32'(seen), 32'd0);
    run_op("after_flush", 32'hFFFF_FF00, 32'd16, 1'b1);

    // Flush in IDLE drops a coincident request.
    @(negedge clk);
    dividend = 32'd9;
    divisor  = 32'd3;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    check("flush_idle_drop", 32'(in_ready), 32'd1);

    // Asynchronous reset in the middle of BUSY.
    start_op(32'd77, 32'd5, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_quotient", quotient, 32'd0);
    check("arst_remainder", remainder, 32'd0);
    check("arst_dz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    run_op("after_reset", 32'd123456, 32'd789, 1'b0);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
